dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 15, sets the bus-wait cycles before abort (range 1..15, held in a 4-bit counter).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 memread_ex_mem  input  1  load request from EX/MEM stage.
REQ-005 memwrite_ex_mem  input  1  store request from EX/MEM stage.
REQ-006 addr_ex_mem  input  32  byte address of access.
REQ-007 wdata_ex_mem  input  32  store data.
REQ-008 bus_req  output  1  memory-bus request, held until bus_ack or timeout.
REQ-009 bus_we  output  1  1 = write, 0 = read; valid while bus_req=1.
REQ-010 bus_addr  output  32  latched address; valid while bus_req=1.
REQ-011 bus_wdata  output  32  latched store data; valid while bus_req=1.
REQ-012 bus_ack  input  1  responder completion, single-cycle pulse.
REQ-013 bus_rdata  input  32  read data, valid when bus_ack=1.
REQ-014 rdata  output  32  registered load result to MEM/WB.
REQ-015 rdata_valid  output  1  one-cycle pulse; rdata holds a new load result.
REQ-016 stall_mem  output  1  full-pipeline freeze request.
REQ-017 bus_err  output  1  sticky flag: timeout or read+write conflict.

Function
REQ-018 FSM states: IDLE, REQ, DONE.
REQ-019 IDLE: if memread_ex_mem|memwrite_ex_mem, stall_mem=1 combinationally in the same cycle, latch addr/wdata/we, go to REQ, clear timeout counter.
REQ-020 IDLE with no request: stall_mem=0, bus_req=0, stay in IDLE.
REQ-021 Both memread and memwrite high in IDLE: perform the write only, set bus_err.
REQ-022 REQ: bus_req=1, stall_mem=1, bus_addr/bus_we/bus_wdata stable.
REQ-023 REQ with bus_ack=1 (including the first REQ cycle): go to DONE; if read, rdata<=bus_rdata.
REQ-024 REQ without ack: counter increments; when counter==TIMEOUT-1 with no ack, set bus_err, rdata<=0 if read, go to DONE.
REQ-025 DONE: stall_mem=0, bus_req=0, rdata_valid=1 if the access was a read; go to IDLE unconditionally.
REQ-026 DONE ignores the memread/memwrite inputs, because they still belong to the completed instruction.
REQ-027 Minimum stall is 2 cycles: the IDLE detect cycle plus one REQ cycle with immediate ack.
REQ-028 Worst-case stall is TIMEOUT+1 cycles.
REQ-029 bus_ack in IDLE or DONE is ignored: no state, rdata or error change.
REQ-030 rdata holds its value until the next completed read; writes never modify it.
REQ-031 bus_err clears only on reset.
REQ-032 Back-to-back accesses: a request present in the cycle after DONE starts a new transaction from IDLE.

Reset
REQ-033 On rst_n=0, immediately (asynchronously): FSM=IDLE, counter=0, rdata=0, rdata_valid=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_err=0.
REQ-034 Reset asserted mid-transaction abandons the access with no bus_err; bus_req drops asynchronously.
REQ-035 After rst_n deasserts, the first request is accepted on the first posedge.

Structure
REQ-036 A shared package holds the FSM state enum, the data/address width constants (32), and the TIMEOUT default.
REQ-037 Single module with no sub-module; the timeout counter and FSM are local.

Verification
REQ-038 Read at 0x0000_0010, ack in first REQ cycle with bus_rdata=0xDEAD_BEEF -> stall_mem high 2 cycles, rdata=0xDEAD_BEEF, rdata_valid pulse in DONE.
REQ-039 Write 0x1234_5678 to 0x20, ack after 3 REQ cycles -> bus_we=1 and bus_wdata stable 3 cycles, stall 4 cycles, rdata unchanged, rdata_valid=0.
REQ-040 Read with no ack, TIMEOUT=15 -> bus_req high 15 cycles, bus_err=1, rdata=0, stall drops in DONE.
REQ-041 memread and memwrite both high -> write issued, bus_err=1, bus_err still 1 after ten idle cycles.
REQ-042 rst_n low in the second REQ cycle -> bus_req, stall_mem and all registers 0 before the next edge; later read completes normally.
REQ-043 Two consecutive loads with immediate acks -> stall pattern 1,1,0,1,1,0; both rdata values correct; stray bus_ack in IDLE is ignored.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and sizing for the data-memory bus bridge.
package dmem_bridge_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_bridge.sv
// Bridges EX/MEM load/store requests onto a req/ack memory bus, freezing the
// pipeline while the access is outstanding and aborting after TIMEOUT cycles.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread_ex_mem,
  input  logic              memwrite_ex_mem,
  input  logic [ADDR_W-1:0] addr_ex_mem,
  input  logic [DATA_W-1:0] wdata_ex_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall_mem,
  output logic              bus_err
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             req_c;
  logic             ack_c;
  logic             expire_c;

  assign req_c    = memread_ex_mem | memwrite_ex_mem;
  assign ack_c    = (state_q == ST_REQ) && bus_ack;
  // Ack on the final wait cycle still wins over the abort.
  assign expire_c = (state_q == ST_REQ) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_c) state_d = ST_REQ;
      ST_REQ:  if (ack_c || expire_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall asserts in the detect cycle itself so the pipeline freezes at once.
  always_comb begin
    bus_req     = 1'b0;
    stall_mem   = 1'b0;
    rdata_valid = 1'b0;
    case (state_q)
      ST_IDLE: stall_mem = req_c;
      ST_REQ: begin
        bus_req   = 1'b1;
        stall_mem = 1'b1;
      end
      ST_DONE: rdata_valid = !bus_we;
      default: ;
    endcase
  end

  // Latched access, wait counter, load result and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_c) begin
        cnt_q     <= '0;
        bus_we    <= memwrite_ex_mem;
        bus_addr  <= addr_ex_mem;
        bus_wdata <= wdata_ex_mem;
        if (memread_ex_mem && memwrite_ex_mem) bus_err <= 1'b1;
      end else if (ack_c) begin
        if (!bus_we) rdata <= bus_rdata;
      end else if (expire_c) begin
        bus_err <= 1'b1;
        if (!bus_we) rdata <= '0;
      end else if (state_q == ST_REQ) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized transaction-level bench for dmem_bridge with a behavioural model.
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread_ex_mem = 1'b0;
  logic        memwrite_ex_mem = 1'b0;
  logic [31:0] addr_ex_mem = '0;
  logic [31:0] wdata_ex_mem = '0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall_mem;
  logic        bus_err;

  dmem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .memread_ex_mem(memread_ex_mem), .memwrite_ex_mem(memwrite_ex_mem),
    .addr_ex_mem(addr_ex_mem), .wdata_ex_mem(wdata_ex_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, written by the driver.
  bit          exp_on = 1'b0;
  bit          exp_stall, exp_req, exp_we, exp_rvalid;
  logic [31:0] exp_addr, exp_wdata;
  logic [31:0] m_rdata = '0;
  bit          m_err = 1'b0;
  int          stall_cnt = 0;
  int          breq_cnt = 0;
  int          stalls, breqs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      check("stall_mem", 32'(stall_mem), 32'(exp_stall));
      check("bus_req", 32'(bus_req), 32'(exp_req));
      if (exp_req) begin
        check("bus_we", 32'(bus_we), 32'(exp_we));
        check("bus_addr", bus_addr, exp_addr);
        check("bus_wdata", bus_wdata, exp_wdata);
      end
      check("rdata_valid", 32'(rdata_valid), 32'(exp_rvalid));
      check("rdata", rdata, m_rdata);
      check("bus_err", 32'(bus_err), 32'(m_err));
      if (stall_mem) stall_cnt++;
      if (bus_req) breq_cnt++;
    end
  end

  task automatic set_idle_exp();
    exp_stall  = 1'b0;
    exp_req    = 1'b0;
    exp_rvalid = 1'b0;
  endtask

  // One access: ack_at = REQ cycle carrying the ack (1..TO), 0 = never acked.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int ack_at,
                     input logic [31:0] rval, input int idle_after);
    bit is_read = rd && !wr;
    int n = (ack_at > 0) ? ack_at : int'(TO);
    stall_cnt = 0;
    breq_cnt  = 0;
    @(posedge clk); #1;
    memread_ex_mem = rd; memwrite_ex_mem = wr;
    addr_ex_mem = addr; wdata_ex_mem = wdata;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    exp_stall = 1'b1; exp_req = 1'b0; exp_rvalid = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      bus_ack   = (k == ack_at);
      bus_rdata = (k == ack_at) ? rval : $urandom;
      if (k == 1 && rd && wr) m_err = 1'b1;
      exp_stall = 1'b1; exp_req = 1'b1;
      exp_we = wr; exp_addr = addr; exp_wdata = wdata;
    end
    @(posedge clk); #1;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    if (is_read) m_rdata = (ack_at > 0) ? rval : 32'h0;
    if (ack_at == 0) m_err = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0; exp_rvalid = is_read;
    @(negedge clk); #1;
    stalls = stall_cnt;
    breqs  = breq_cnt;
    for (int i = 0; i < idle_after; i++) begin
      @(posedge clk); #1;
      memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0;
      bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      set_idle_exp();
    end
  endtask

  task automatic apply_reset();
    exp_on = 1'b0;
    rst_n = 1'b0;
    memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0; bus_ack = 1'b0;
    m_rdata = '0; m_err = 1'b0;
    set_idle_exp();
    #1;
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_stall", 32'(stall_mem), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(bus_err), 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_we", 32'(bus_we), 32'h0);
    check("rst_rvalid", 32'(rdata_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 exp_on = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle_exp();
    #2;
    apply_reset();

    // Single-cycle ack read.
    txn(1'b1, 1'b0, 32'h10, $urandom, 1, 32'hDEAD_BEEF, 2);
    check("read_stalls", 32'(stalls), 32'd2);
    check("read_rdata", rdata, 32'hDEAD_BEEF);

    // Write acked in third REQ cycle leaves rdata untouched.
    txn(1'b0, 1'b1, 32'h20, 32'h1234_5678, 3, $urandom, 1);
    check("write_stalls", 32'(stalls), 32'd4);
    check("write_breqs", 32'(breqs), 32'd3);
    check("write_rdata", rdata, 32'hDEAD_BEEF);

    // Ack on the last allowed cycle still succeeds.
    txn(1'b1, 1'b0, 32'h24, $urandom, int'(TO), 32'h5555_AAAA, 1);
    check("lateack_stalls", 32'(stalls), 32'(TO + 1));
    check("lateack_err", 32'(bus_err), 32'h0);

    // Unacknowledged read times out.
    txn(1'b1, 1'b0, 32'h30, $urandom, 0, $urandom, 1);
    check("to_breqs", 32'(breqs), 32'(TO));
    check("to_stalls", 32'(stalls), 32'(TO + 1));
    check("to_err", 32'(bus_err), 32'h1);
    check("to_rdata", rdata, 32'h0);

    apply_reset();
    txn(1'b1, 1'b0, 32'h34, $urandom, 2, 32'h7777_1111, 0);
    // Read+write conflict: write wins, error sticks through idle time.
    txn(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 2, $urandom, 10);
    check("conflict_err", 32'(bus_err), 32'h1);
    check("conflict_rdata", rdata, 32'h7777_1111);

    // Reset dropped in the second REQ cycle.
    @(posedge clk); #1;
    memread_ex_mem = 1'b1; addr_ex_mem = 32'h50; bus_ack = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0;
      exp_addr = 32'h50; exp_wdata = wdata_ex_mem;
    end
    #1;
    apply_reset();
    txn(1'b1, 1'b0, 32'h60, $urandom, 2, 32'h0BAD_F00D, 1);
    check("post_rst_rdata", rdata, 32'h0BAD_F00D);

    // Back-to-back loads.
    txn(1'b1, 1'b0, 32'h70, $urandom, 1, 32'hA1A1_A1A1, 0);
    check("b2b_stalls0", 32'(stalls), 32'd2);
    txn(1'b1, 1'b0, 32'h74, $urandom, 1, 32'hB2B2_B2B2, 3);
    check("b2b_stalls1", 32'(stalls), 32'd2);
    check("b2b_rdata", rdata, 32'hB2B2_B2B2);

    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 7);
      bit rd = (kind < 4) || (kind == 7);
      bit wr = (kind >= 4);
      int ack_at = ($urandom_range(0, 5) == 0) ? 0 :
                   (($urandom_range(0, 4) == 0) ? $urandom_range(5, TO) : $urandom_range(1, 4));
      txn(rd, wr, $urandom, $urandom, ack_at, $urandom, $urandom_range(0, 2));
    end
    txn(1'b1, 1'b0, 32'h80, $urandom, 1, 32'h1357_9BDF, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
